// File: rtl/macro_credit_tx3_if.sv
// Handshake, payload and credit-status bundle between the producer side and
// the credit gate; the gate takes the slave modport.
interface macro_credit_tx3_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  credit_return;
  logic                  credit_reinit;
  logic [2:0]            credit_count;
  logic                  credit_empty;
  logic                  err_overflow;
  logic                  busy;

  modport master (
    output i_valid, i_data, credit_return, credit_reinit,
    input  i_ready, o_valid, o_data, credit_count, credit_empty, err_overflow, busy
  );

  modport slave (
    input  i_valid, i_data, credit_return, credit_reinit,
    output i_ready, o_valid, o_data, credit_count, credit_empty, err_overflow, busy
  );
endinterface

// File: rtl/macro_credit_tx3.sv
// Transmit-side credit gate: spends one credit per accepted beat, regains one
// per receiver return, and supports a drain/re-initialise sequence.
module macro_credit_tx3 #(
  parameter int CREDIT_INIT = 7,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  macro_credit_tx3_if.slave    bus
);
  localparam logic [2:0] CREDIT_MAX = 3'(CREDIT_INIT);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  logic [2:0]            count_q, count_d;
  logic                  err_q, err_d;
  logic                  o_valid_q;
  logic [DATA_WIDTH-1:0] o_data_q;
  logic                  ready;
  logic                  fire;
  logic                  drain_done;

  // Readiness depends on registered state only, so a return is usable next cycle.
  assign ready      = (state_q == ST_RUN) && (count_q != 3'd0);
  assign fire       = bus.i_valid && ready;
  assign drain_done = (state_q == ST_DRAIN) && (count_q == CREDIT_MAX);

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (state_q != ST_INIT) begin
      if (fire && !bus.credit_return) begin
        count_d = count_q - 3'd1;
      end else if (!fire && bus.credit_return) begin
        if (count_q < CREDIT_MAX) begin
          count_d = count_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    // Leaving drain starts the link with a clean error history.
    if (drain_done) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      count_q   <= CREDIT_MAX;
      err_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      count_q   <= count_d;
      err_q     <= err_d;
      o_valid_q <= fire;
      if (fire) begin
        o_data_q <= bus.i_data;
      end
      case (state_q)
        ST_INIT: state_q <= ST_RUN;
        ST_RUN: begin
          if (bus.credit_reinit) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign bus.i_ready      = ready;
  assign bus.o_valid      = o_valid_q;
  assign bus.o_data       = o_data_q;
  assign bus.credit_count = count_q;
  assign bus.credit_empty = (count_q == 3'd0);
  assign bus.err_overflow = err_q;
  assign bus.busy         = (state_q != ST_RUN);
endmodule

// File: tb/tb_macro_credit_tx3.sv
// Randomised and directed bench for macro_credit_tx3 against an integer credit
// model with a start/run/drain phase variable.
module tb_macro_credit_tx3;
  localparam int CI = 7;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  macro_credit_tx3_if #(.DATA_WIDTH(DW)) bus ();

  macro_credit_tx3 #(.CREDIT_INIT(CI), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = starting up, 1 = running, 2 = draining.
  int          m_phase;
  int          m_cred;
  bit          m_err;
  bit          m_ovalid;
  logic [63:0] m_odata;
  int          fires_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_cred   = CI;
    m_err    = 0;
    m_ovalid = 0;
    m_odata  = '0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":i_ready"}, 64'(bus.i_ready), 64'((m_phase == 1) && (m_cred > 0)));
    chk({ctx, ":o_valid"}, 64'(bus.o_valid), 64'(m_ovalid));
    chk({ctx, ":o_data"}, bus.o_data, m_odata);
    chk({ctx, ":count"}, 64'(bus.credit_count), 64'(m_cred));
    chk({ctx, ":empty"}, 64'(bus.credit_empty), 64'(m_cred == 0));
    chk({ctx, ":err"}, 64'(bus.err_overflow), 64'(m_err));
    chk({ctx, ":busy"}, 64'(bus.busy), 64'(m_phase != 1));
  endtask

  task automatic set_in(input bit v, input logic [63:0] d, input bit ret, input bit reinit);
    bus.i_valid       = v;
    bus.i_data        = d;
    bus.credit_return = ret;
    bus.credit_reinit = reinit;
  endtask

  // One clock: decide acceptance from model state, advance the model, compare.
  task automatic step(input string ctx);
    bit          f;
    bit          r;
    bit          ri;
    logic [63:0] d;
    int          old_cred;
    f  = bus.i_valid && (m_phase == 1) && (m_cred > 0);
    r  = bus.credit_return;
    ri = bus.credit_reinit;
    d  = bus.i_data;
    @(posedge clk);
    old_cred = m_cred;
    m_ovalid = f;
    if (f) begin
      m_odata = d;
      fires_seen++;
    end
    if (m_phase == 0) begin
      m_phase = 1;
    end else begin
      if (f && !r) m_cred = m_cred - 1;
      else if (r && !f) begin
        if (m_cred < CI) m_cred = m_cred + 1;
        else m_err = 1;
      end
      if (m_phase == 1 && ri) m_phase = 2;
      else if (m_phase == 2 && old_cred == CI) begin
        m_phase = 1;
        m_err   = 0;
      end
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    int p0;
    int ret_pat[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
    set_in(0, '0, 0, 0);
    model_reset();
    fires_seen = 0;
    #12;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("post_reset");
    step("init_to_run");
    chk("run_count7", 64'(bus.credit_count), 64'd7);

    // Exhaust credits with payload 0x10..0x16, then one extra attempt.
    for (int k = 0; k < 7; k++) begin
      set_in(1, 64'(16 + k), 0, 0);
      step("exhaust");
      chk("exhaust_data", bus.o_data, 64'(16 + k));
    end
    set_in(1, 64'h99, 0, 0);
    step("empty_hold");
    chk("empty_flag", 64'(bus.credit_empty), 64'd1);
    set_in(0, '0, 1, 0);
    step("first_return");
    chk("ret_count1", 64'(bus.credit_count), 64'd1);
    for (int k = 0; k < 6; k++) begin
      set_in(0, '0, 1, 0);
      step("refill");
    end

    // Fire and return together at the ceiling.
    p0 = fires_seen;
    for (int k = 0; k < 5; k++) begin
      set_in(1, 64'(32 + k), 1, 0);
      step("simul");
    end
    set_in(0, '0, 0, 0);
    step("simul_tail");
    chk("simul_pulses", 64'(fires_seen - p0), 64'd5);

    // Overflow, sticky through further traffic.
    set_in(0, '0, 1, 0);
    step("overflow");
    chk("overflow_set", 64'(bus.err_overflow), 64'd1);
    for (int k = 0; k < 4; k++) begin
      set_in(1, 64'(48 + k), 0, 0);
      step("sticky");
    end

    // Drain from 3 credits while firing, then return 5 over 8 cycles.
    set_in(0, '0, 0, 0);
    step("pre_drain");
    chk("drain_start3", 64'(bus.credit_count), 64'd3);
    set_in(1, 64'hD0, 0, 1);
    step("drain_enter");
    for (int k = 0; k < 8; k++) begin
      set_in(1, 64'hE0, ret_pat[k] == 1, 1);
      step("drain");
    end
    set_in(0, '0, 0, 0);
    step("drain_exit");
    chk("drain_err_clr", 64'(bus.err_overflow), 64'd0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 9) < 7, {$urandom, $urandom},
             $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      step("rand");
    end

    // Reach DRAIN with o_valid=1 and count=4, then reset without a clock edge.
    set_in(0, '0, 0, 0);
    for (int k = 0; k < 12 && m_phase != 1; k++) step("settle");
    for (int k = 0; k < 8; k++) begin
      set_in(0, '0, m_cred < CI, 0);
      step("fill");
    end
    for (int k = 0; k < 2; k++) begin
      set_in(1, 64'hA0 + 64'(k), 0, 0);
      step("to5");
    end
    set_in(1, 64'hABCD, 0, 1);
    step("drain4");
    chk("pre_rst_valid", 64'(bus.o_valid), 64'd1);
    chk("pre_rst_count", 64'(bus.credit_count), 64'd4);
    set_in(0, '0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_o_valid", 64'(bus.o_valid), 64'd0);
    chk("async_o_data", bus.o_data, 64'd0);
    chk("async_count", 64'(bus.credit_count), 64'd7);
    chk("async_err", 64'(bus.err_overflow), 64'd0);
    chk("async_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all("rst2");
    step("rst2_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
